// File: rtl/pc_redirect_unit_pkg.sv
// Shared definitions for the PC redirect slice: FSM encoding, reset PC
// default and the width of the statistics counters.
package pc_redirect_unit_pkg;

    localparam logic [1:0] ST_RUN_ENC   = 2'd0;
    localparam logic [1:0] ST_HOLD_ENC  = 2'd1;
    localparam logic [1:0] ST_FLUSH_ENC = 2'd2;
    localparam logic [1:0] ST_HALT_ENC  = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN   = ST_RUN_ENC,
        ST_HOLD  = ST_HOLD_ENC,
        ST_FLUSH = ST_FLUSH_ENC,
        ST_HALT  = ST_HALT_ENC
    } state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam int              CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/sat_counter16.sv
// Enable-driven event counter that sticks at its maximum value instead of
// wrapping; shared by the redirect and branch statistics.
module sat_counter16
    import pc_redirect_unit_pkg::*;
(
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/pc_redirect_unit.sv
// Architectural PC register: applies next-PC updates under stall control,
// defers stalled redirects, opens an IF/ID flush window and counts redirects.
module pc_redirect_unit
    import pc_redirect_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int          FLUSH_DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pcen,
    input  logic [31:0]      npc_in,
    input  logic             redirect,
    input  logic             halt_req,
    output logic [31:0]      pc,
    output logic             if_flush,
    output logic             halted,
    output logic [CNT_W-1:0] redir_cnt,
    output logic             redir_pending
);

    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_DEPTH);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic        pending_q, pending_d;
    logic        if_flush_q, if_flush_d;
    logic        halted_q, halted_d;
    logic [1:0]  flush_cnt_q, flush_cnt_d;
    logic        redir_apply;

    // Redirect and halt are only looked at in RUN/HOLD, so the flush window
    // naturally masks them while the ID instruction is being squashed.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_d      = pend_q;
        pending_d   = pending_q;
        if_flush_d  = if_flush_q;
        halted_d    = halted_q;
        flush_cnt_d = flush_cnt_q;
        redir_apply = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (pcen && halt_req) begin
                    halted_d = 1'b1;
                    state_d  = ST_HALT;
                end else if (pcen && redirect) begin
                    pc_d        = npc_in;
                    flush_cnt_d = FLUSH_INIT;
                    if_flush_d  = 1'b1;
                    redir_apply = 1'b1;
                    state_d     = ST_FLUSH;
                end else if (redirect) begin
                    pend_d    = npc_in;
                    pending_d = 1'b1;
                    state_d   = ST_HOLD;
                end else if (pcen) begin
                    pc_d = npc_in;
                end
            end
            ST_HOLD: begin
                if (pcen) begin
                    pc_d        = pend_q;
                    pending_d   = 1'b0;
                    flush_cnt_d = FLUSH_INIT;
                    if_flush_d  = 1'b1;
                    redir_apply = 1'b1;
                    state_d     = ST_FLUSH;
                end else if (redirect) begin
                    pend_d = npc_in;
                end
            end
            ST_FLUSH: begin
                if (pcen) begin
                    pc_d = npc_in;
                end
                flush_cnt_d = flush_cnt_q - 2'd1;
                if (flush_cnt_d == 2'd0) begin
                    if_flush_d = 1'b0;
                    state_d    = ST_RUN;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC;
            pend_q      <= '0;
            pending_q   <= 1'b0;
            if_flush_q  <= 1'b0;
            halted_q    <= 1'b0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            pending_q   <= pending_d;
            if_flush_q  <= if_flush_d;
            halted_q    <= halted_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    sat_counter16 u_redir_cnt (
        .clk   (clk),
        .clr_n (rst_n),
        .en    (redir_apply),
        .count (redir_cnt)
    );

    assign pc            = pc_q;
    assign if_flush      = if_flush_q;
    assign halted        = halted_q;
    assign redir_pending = pending_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Self-checking bench for pc_redirect_unit: table-driven vectors through a
// scoreboard queue, hand-written reset/flush sequences and a saturation run.
module tb_pc_redirect_unit;

    typedef struct {
        logic        pcen;
        logic        redirect;
        logic        halt_req;
        logic [31:0] npc;
        logic [31:0] exp_pc;
        logic        exp_flush;
        logic        exp_halted;
        logic [15:0] exp_cnt;
        logic        exp_pend;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        pcen;
    logic [31:0] npc_in;
    logic        redirect;
    logic        halt_req;

    logic [31:0] pc1, pc2;
    logic        if_flush1, if_flush2;
    logic        halted1, halted2;
    logic [15:0] redir_cnt1, redir_cnt2;
    logic        redir_pending1, redir_pending2;

    logic        sat_clr_n;
    logic        sat_en;
    logic [15:0] sat_count;

    logic        sel;
    int          checks;
    int          errors;
    vec_t        exp_q[$];
    vec_t        tbl[$];

    pc_redirect_unit #(.RESET_PC(32'h0000_0000), .FLUSH_DEPTH(1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pcen          (pcen),
        .npc_in        (npc_in),
        .redirect      (redirect),
        .halt_req      (halt_req),
        .pc            (pc1),
        .if_flush      (if_flush1),
        .halted        (halted1),
        .redir_cnt     (redir_cnt1),
        .redir_pending (redir_pending1)
    );

    pc_redirect_unit #(.RESET_PC(32'h0000_3000), .FLUSH_DEPTH(2)) dut2 (
        .clk           (clk),
        .rst_n         (rst_n),
        .pcen          (pcen),
        .npc_in        (npc_in),
        .redirect      (redirect),
        .halt_req      (halt_req),
        .pc            (pc2),
        .if_flush      (if_flush2),
        .halted        (halted2),
        .redir_cnt     (redir_cnt2),
        .redir_pending (redir_pending2)
    );

    sat_counter16 u_sat (
        .clk   (clk),
        .clr_n (sat_clr_n),
        .en    (sat_en),
        .count (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic p, logic r, logic h, logic [31:0] n,
                                logic [31:0] epc, logic ef, logic eh,
                                logic [15:0] ec, logic ep);
        vec_t v;
        v.pcen = p; v.redirect = r; v.halt_req = h; v.npc = n;
        v.exp_pc = epc; v.exp_flush = ef; v.exp_halted = eh;
        v.exp_cnt = ec; v.exp_pend = ep;
        return v;
    endfunction

    task automatic check_val(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Pops the oldest expectation and compares it to the selected DUT.
    task automatic checkOutput(string nm);
        vec_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: got empty scoreboard expected an entry", nm);
            return;
        end
        e = exp_q.pop_front();
        check_val({nm, ".pc"},      sel ? pc2 : pc1, e.exp_pc);
        check_val({nm, ".flush"},   32'(sel ? if_flush2 : if_flush1), 32'(e.exp_flush));
        check_val({nm, ".halted"},  32'(sel ? halted2 : halted1), 32'(e.exp_halted));
        check_val({nm, ".cnt"},     32'(sel ? redir_cnt2 : redir_cnt1), 32'(e.exp_cnt));
        check_val({nm, ".pending"}, 32'(sel ? redir_pending2 : redir_pending1), 32'(e.exp_pend));
    endtask

    // Drives one vector on the falling edge and compares just after the rise.
    task automatic applyStimulus(vec_t v, string nm);
        @(negedge clk);
        pcen     = v.pcen;
        redirect = v.redirect;
        halt_req = v.halt_req;
        npc_in   = v.npc;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        checkOutput(nm);
    endtask

    task automatic idle_inputs();
        pcen = 1'b0; redirect = 1'b0; halt_req = 1'b0; npc_in = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        sel = 1'b0;
        sat_clr_n = 1'b0;
        sat_en = 1'b0;
        rst_n = 1'b0;
        idle_inputs();

        // fields: pcen redirect halt npc | pc flush halted cnt pending
        tbl.push_back(mk(1, 0, 0, 32'h04,  32'h04, 0, 0, 16'd0, 0));
        tbl.push_back(mk(1, 0, 0, 32'h08,  32'h08, 0, 0, 16'd0, 0));
        tbl.push_back(mk(1, 0, 0, 32'h0C,  32'h0C, 0, 0, 16'd0, 0));
        tbl.push_back(mk(1, 0, 0, 32'h10,  32'h10, 0, 0, 16'd0, 0));
        tbl.push_back(mk(1, 1, 0, 32'h40,  32'h40, 1, 0, 16'd1, 0));
        tbl.push_back(mk(1, 1, 0, 32'h44,  32'h44, 0, 0, 16'd1, 0));
        tbl.push_back(mk(1, 0, 0, 32'h48,  32'h48, 0, 0, 16'd1, 0));
        tbl.push_back(mk(0, 0, 0, 32'h4C,  32'h48, 0, 0, 16'd1, 0));
        tbl.push_back(mk(0, 1, 0, 32'h80,  32'h48, 0, 0, 16'd1, 1));
        tbl.push_back(mk(0, 0, 0, 32'h4C,  32'h48, 0, 0, 16'd1, 1));
        tbl.push_back(mk(0, 1, 0, 32'h90,  32'h48, 0, 0, 16'd1, 1));
        tbl.push_back(mk(0, 0, 1, 32'h4C,  32'h48, 0, 0, 16'd1, 1));
        tbl.push_back(mk(1, 0, 1, 32'h4C,  32'h90, 1, 0, 16'd2, 0));
        tbl.push_back(mk(0, 0, 0, 32'h94,  32'h90, 0, 0, 16'd2, 0));
        tbl.push_back(mk(1, 0, 0, 32'h94,  32'h94, 0, 0, 16'd2, 0));
        tbl.push_back(mk(1, 1, 0, 32'h03,  32'h03, 1, 0, 16'd3, 0));
        tbl.push_back(mk(1, 0, 1, 32'h07,  32'h07, 0, 0, 16'd3, 0));
        tbl.push_back(mk(1, 1, 1, 32'h200, 32'h07, 0, 1, 16'd3, 0));
        tbl.push_back(mk(1, 1, 0, 32'h300, 32'h07, 0, 1, 16'd3, 0));
        tbl.push_back(mk(0, 1, 0, 32'h400, 32'h07, 0, 1, 16'd3, 0));

        repeat (2) @(negedge clk);
        exp_q.push_back(mk(0, 0, 0, 0, 32'h0, 0, 0, 16'd0, 0));
        checkOutput("reset");
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i], $sformatf("v%0d", i));
        end

        // Leaving HALT only via reset, which takes effect without a clock.
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        #1;
        exp_q.push_back(mk(0, 0, 0, 0, 32'h0, 0, 0, 16'd0, 0));
        checkOutput("halt_reset");
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(mk(1, 0, 0, 32'h20, 32'h20, 0, 0, 16'd0, 0), "pre_hold");
        applyStimulus(mk(0, 1, 0, 32'h80, 32'h20, 0, 0, 16'd0, 1), "hold_enter");
        @(negedge clk);
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(mk(0, 0, 0, 0, 32'h0, 0, 0, 16'd0, 0));
        checkOutput("async_reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(mk(1, 0, 0, 32'h04, 32'h04, 0, 0, 16'd0, 0), "after_hold_reset");

        // Two-cycle flush window on the second instance.
        sel = 1'b1;
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        #1;
        exp_q.push_back(mk(0, 0, 0, 0, 32'h3000, 0, 0, 16'd0, 0));
        checkOutput("d2_reset");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(mk(1, 0, 0, 32'h3004, 32'h3004, 0, 0, 16'd0, 0), "d2_seq");
        applyStimulus(mk(1, 1, 0, 32'h100,  32'h100,  1, 0, 16'd1, 0), "d2_redir");
        applyStimulus(mk(1, 1, 0, 32'h104,  32'h104,  1, 0, 16'd1, 0), "d2_flush2");
        applyStimulus(mk(1, 1, 1, 32'h108,  32'h108,  0, 0, 16'd1, 0), "d2_flush_end");
        applyStimulus(mk(1, 0, 0, 32'h10C,  32'h10C,  0, 0, 16'd1, 0), "d2_run");
        sel = 1'b0;

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
        end

        // Saturation: counter enabled every cycle past its maximum.
        @(negedge clk);
        idle_inputs();
        sat_clr_n = 1'b1;
        sat_en = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        check_val("sat_fffe", 32'(sat_count), 32'h0000_FFFE);
        @(posedge clk);
        #1;
        check_val("sat_ffff", 32'(sat_count), 32'h0000_FFFF);
        repeat (3) @(posedge clk);
        #1;
        check_val("sat_hold", 32'(sat_count), 32'h0000_FFFF);
        sat_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
